// File: rtl/ahb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : ahb_trace_capture
// Brief    : Follows the delayed AHB address/data pipeline, records every
//            completed transfer into a first-word-fall-through trace FIFO
//            and exposes the FIFO head to a debug/host read port.
//            Optional macro AHB_TRACE_TIMESTAMP_EN adds a 16-bit cycle
//            timestamp per entry; without it rd_tstamp is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_trace_capture #(
  parameter int HAMAX = 32,
  parameter int HDMAX = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic             hsel_d,
  input  logic             hready_ba_d,
  input  logic             hwrite_d,
  input  logic             hmastlock_d,
  input  logic [HAMAX-1:0] haddr_d,
  input  logic [1:0]       htrans_d,
  input  logic [2:0]       hsize_d,
  input  logic [2:0]       hburst_d,
  input  logic [HDMAX-1:0] hwdata_d,
  input  logic [3:0]       hmaster_d,
  input  logic             enable,
  input  logic             rd_en,
  input  logic             overflow_clr,
  output logic             rd_valid,
  output logic [HAMAX-1:0] rd_addr,
  output logic [HDMAX-1:0] rd_data,
  output logic             rd_write,
  output logic             rd_lock,
  output logic [2:0]       rd_size,
  output logic [2:0]       rd_burst,
  output logic [3:0]       rd_master,
  output logic [15:0]      rd_tstamp,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_complete;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_full;
  logic w_unused;

  // Pending (address-phase) register
  logic [HAMAX-1:0] r_p_addr;
  logic             r_p_write;
  logic             r_p_lock;
  logic [2:0]       r_p_size;
  logic [2:0]       r_p_burst;
  logic [3:0]       r_p_master;

  // FIFO storage and control
  logic [HAMAX-1:0] r_mem_addr   [DEPTH];
  logic [HDMAX-1:0] r_mem_data   [DEPTH];
  logic             r_mem_write  [DEPTH];
  logic             r_mem_lock   [DEPTH];
  logic [2:0]       r_mem_size   [DEPTH];
  logic [2:0]       r_mem_burst  [DEPTH];
  logic [3:0]       r_mem_master [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [7:0]       r_drop_cnt;

  // Only the upper htrans bit matters: NONSEQ/SEQ vs IDLE/BUSY.
  assign w_unused = htrans_d[0];

  assign w_accept = hsel_d & hready_ba_d & htrans_d[1] & enable;

  // State register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a completing data phase may overlap a new address phase
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hready_ba_d) begin
          w_complete  = 1'b1;
          w_state_nxt = w_accept ? ST_DATA : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch address-phase control on accept
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_p_addr   <= '0;
      r_p_write  <= 1'b0;
      r_p_lock   <= 1'b0;
      r_p_size   <= '0;
      r_p_burst  <= '0;
      r_p_master <= '0;
    end else if (w_accept) begin
      r_p_addr   <= haddr_d;
      r_p_write  <= hwrite_d;
      r_p_lock   <= hmastlock_d;
      r_p_size   <= hsize_d;
      r_p_burst  <= hburst_d;
      r_p_master <= hmaster_d;
    end
  end

  // A full FIFO still accepts a push if the head leaves at the same edge.
  assign w_full = (r_count == c_full_count);
  assign w_pop  = rd_en & (r_count != '0);
  assign w_push = w_complete & (~w_full | w_pop);
  assign w_drop = w_complete & w_full & ~w_pop;

  // Entry storage; contents are only observed through the valid-gated head
  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]   <= r_p_addr;
      r_mem_data[r_wr_ptr]   <= r_p_write ? hwdata_d : '0;
      r_mem_write[r_wr_ptr]  <= r_p_write;
      r_mem_lock[r_wr_ptr]   <= r_p_lock;
      r_mem_size[r_wr_ptr]   <= r_p_size;
      r_mem_burst[r_wr_ptr]  <= r_p_burst;
      r_mem_master[r_wr_ptr] <= r_p_master;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (overflow_clr) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

`ifdef AHB_TRACE_TIMESTAMP_EN
  logic [15:0] r_tstamp;
  logic [15:0] r_p_tstamp;
  logic [15:0] r_mem_ts [DEPTH];

  // Free-running cycle counter
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_tstamp <= '0;
    end else begin
      r_tstamp <= r_tstamp + 16'd1;
    end
  end

  // Timestamp captured with the address phase
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_p_tstamp <= '0;
    end else if (w_accept) begin
      r_p_tstamp <= r_tstamp;
    end
  end

  // Per-entry timestamp storage
  always_ff @(posedge hclk) begin
    if (w_push) begin
      r_mem_ts[r_wr_ptr] <= r_p_tstamp;
    end
  end

  assign rd_tstamp = rd_valid ? r_mem_ts[r_rd_ptr] : '0;
`else
  assign rd_tstamp = '0;
`endif

  assign rd_valid  = (r_count != '0);
  assign rd_addr   = rd_valid ? r_mem_addr[r_rd_ptr]   : '0;
  assign rd_data   = rd_valid ? r_mem_data[r_rd_ptr]   : '0;
  assign rd_write  = rd_valid ? r_mem_write[r_rd_ptr]  : 1'b0;
  assign rd_lock   = rd_valid ? r_mem_lock[r_rd_ptr]   : 1'b0;
  assign rd_size   = rd_valid ? r_mem_size[r_rd_ptr]   : '0;
  assign rd_burst  = rd_valid ? r_mem_burst[r_rd_ptr]  : '0;
  assign rd_master = rd_valid ? r_mem_master[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ahb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_trace_capture
// Brief    : Scoreboard bench for ahb_trace_capture. Stimulus queues the
//            expected trace entries; a monitor drains the FIFO and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_trace_capture;

  localparam logic [1:0] c_idle   = 2'b00;
  localparam logic [1:0] c_busy   = 2'b01;
  localparam logic [1:0] c_nonseq = 2'b10;
  localparam logic [1:0] c_seq    = 2'b11;

  logic        hclk;
  logic        hreset;
  logic        hsel_d;
  logic        hready_ba_d;
  logic        hwrite_d;
  logic        hmastlock_d;
  logic [31:0] haddr_d;
  logic [1:0]  htrans_d;
  logic [2:0]  hsize_d;
  logic [2:0]  hburst_d;
  logic [31:0] hwdata_d;
  logic [3:0]  hmaster_d;
  logic        enable;
  logic        rd_en;
  logic        overflow_clr;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_write;
  logic        rd_lock;
  logic [2:0]  rd_size;
  logic [2:0]  rd_burst;
  logic [3:0]  rd_master;
  logic [15:0] rd_tstamp;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int          checks;
  int          errors;
  logic        drain;
  logic        g_lock;
  logic [3:0]  g_master;
  logic [15:0] tb_cnt;
  logic [91:0] exp_q [$];

  ahb_trace_capture dut (
    .hclk(hclk), .hreset(hreset), .hsel_d(hsel_d), .hready_ba_d(hready_ba_d),
    .hwrite_d(hwrite_d), .hmastlock_d(hmastlock_d), .haddr_d(haddr_d),
    .htrans_d(htrans_d), .hsize_d(hsize_d), .hburst_d(hburst_d),
    .hwdata_d(hwdata_d), .hmaster_d(hmaster_d), .enable(enable),
    .rd_en(rd_en), .overflow_clr(overflow_clr), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_write(rd_write),
    .rd_lock(rd_lock), .rd_size(rd_size), .rd_burst(rd_burst),
    .rd_master(rd_master), .rd_tstamp(rd_tstamp), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Reference cycle counter for expected timestamps
  always @(posedge hclk) begin
    if (hreset) tb_cnt <= 16'd0;
    else        tb_cnt <= tb_cnt + 16'd1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Queue an expected entry; the timestamp is the counter at the accept edge
  task automatic exp_push(input logic [31:0] addr, input logic [31:0] data,
                          input logic wr, input logic [2:0] burst);
    logic [15:0] ts;
`ifdef AHB_TRACE_TIMESTAMP_EN
    ts = tb_cnt;
`else
    ts = 16'd0;
`endif
    exp_q.push_back({addr, data, wr, g_lock, 3'd2, burst, g_master, ts});
  endtask

  // Present one bus cycle from a falling edge to the next falling edge
  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] burst,
                       input logic [31:0] wdata, input logic rdy, input logic en);
    hsel_d      = sel;
    htrans_d    = trans;
    hwrite_d    = wr;
    haddr_d     = addr;
    hburst_d    = burst;
    hwdata_d    = wdata;
    hready_ba_d = rdy;
    enable      = en;
    hsize_d     = 3'd2;
    hmastlock_d = g_lock;
    hmaster_d   = g_master;
    @(negedge hclk);
  endtask

  task automatic idle_cycle(input logic [31:0] wdata);
    drive(1'b1, c_idle, 1'b0, 32'h0, 3'd0, wdata, 1'b1, 1'b1);
  endtask

  // Let the monitor empty the FIFO, bounded
  task automatic wait_drain(input int budget);
    bit done;
    done  = 1'b0;
    drain = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge hclk);
      #2;
      if (!rd_valid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    drain = 1'b0;
    chk("drain_complete", {127'd0, done}, 128'd1);
    chk("drain_count", {123'd0, count}, 128'd0);
  endtask

  // Monitor: compare and pop the head whenever draining is allowed
  initial begin
    logic [91:0] obs;
    rd_en = 1'b0;
    forever begin
      @(negedge hclk);
      #1;
      if (drain && rd_valid) begin
        obs = {rd_addr, rd_data, rd_write, rd_lock, rd_size, rd_burst, rd_master, rd_tstamp};
        if (exp_q.size() == 0) begin
          chk("unexpected_entry", {36'd0, obs}, 128'd0);
        end else begin
          chk("entry", {36'd0, obs}, {36'd0, exp_q.pop_front()});
        end
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
    end
  end

  initial begin
    checks = 0; errors = 0; drain = 1'b0;
    g_lock = 1'b0; g_master = 4'd0;
    hreset = 1'b1; overflow_clr = 1'b0;
    hsel_d = 0; hready_ba_d = 1; hwrite_d = 0; hmastlock_d = 0; haddr_d = 0;
    htrans_d = c_idle; hsize_d = 0; hburst_d = 0; hwdata_d = 0; hmaster_d = 0; enable = 1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("reset_rd_valid", {127'd0, rd_valid}, 128'd0);
    chk("reset_count", {123'd0, count}, 128'd0);
    chk("reset_overflow", {127'd0, overflow}, 128'd0);
    chk("reset_drop_cnt", {120'd0, drop_cnt}, 128'd0);
    chk("reset_rd_fields", {36'd0, rd_addr, rd_data, rd_write, rd_lock, rd_size,
                            rd_burst, rd_master, rd_tstamp}, 128'd0);
    hreset = 1'b0;
    @(negedge hclk);

    // Single NONSEQ write
    exp_push(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 3'd0);
    drive(1'b1, c_nonseq, 1'b1, 32'h0000_1000, 3'd0, 32'h0, 1'b1, 1'b1);
    idle_cycle(32'hDEAD_BEEF);
    chk("single_rd_valid", {127'd0, rd_valid}, 128'd1);
    chk("single_count", {123'd0, count}, 128'd1);
    chk("single_rd_addr", {96'd0, rd_addr}, 128'h1000);
    chk("single_rd_data", {96'd0, rd_data}, 128'hDEAD_BEEF);
    chk("single_rd_write", {127'd0, rd_write}, 128'd1);
    wait_drain(10);

    // INCR4 read burst, two wait states on the second beat
    g_lock = 1'b1; g_master = 4'd5;
    exp_push(32'h2000, 32'h0, 1'b0, 3'd3);
    drive(1'b1, c_nonseq, 1'b0, 32'h2000, 3'd3, 32'hBAD0_0000, 1'b1, 1'b1);
    exp_push(32'h2004, 32'h0, 1'b0, 3'd3);
    drive(1'b1, c_seq, 1'b0, 32'h2004, 3'd3, 32'hBAD0_0001, 1'b1, 1'b1);
    drive(1'b1, c_seq, 1'b0, 32'h2008, 3'd3, 32'hBAD0_0002, 1'b0, 1'b1);
    drive(1'b1, c_seq, 1'b0, 32'h2008, 3'd3, 32'hBAD0_0003, 1'b0, 1'b1);
    chk("burst_wait_count", {123'd0, count}, 128'd1);
    exp_push(32'h2008, 32'h0, 1'b0, 3'd3);
    drive(1'b1, c_seq, 1'b0, 32'h2008, 3'd3, 32'hBAD0_0004, 1'b1, 1'b1);
    exp_push(32'h200C, 32'h0, 1'b0, 3'd3);
    drive(1'b1, c_seq, 1'b0, 32'h200C, 3'd3, 32'hBAD0_0005, 1'b1, 1'b1);
    idle_cycle(32'hBAD0_0006);
    chk("burst_count", {123'd0, count}, 128'd4);
    wait_drain(20);

    // Filtering: IDLE, BUSY, unselected, disabled never captured
    g_lock = 1'b0; g_master = 4'd2;
    drive(1'b1, c_idle,   1'b1, 32'h6000, 3'd0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, c_busy,   1'b1, 32'h6004, 3'd0, 32'h0, 1'b1, 1'b1);
    drive(1'b0, c_nonseq, 1'b1, 32'h6008, 3'd0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, c_nonseq, 1'b1, 32'h600C, 3'd0, 32'h0, 1'b1, 1'b0);
    idle_cycle(32'h0);
    chk("filter_count", {123'd0, count}, 128'd0);
    // enable dropped during the data phase: the pending write still lands
    exp_push(32'h6010, 32'h1234_5678, 1'b1, 3'd0);
    drive(1'b1, c_nonseq, 1'b1, 32'h6010, 3'd0, 32'h0, 1'b1, 1'b1);
    drive(1'b1, c_nonseq, 1'b1, 32'h6014, 3'd0, 32'h1234_5678, 1'b1, 1'b0);
    idle_cycle(32'h0);
    chk("filter_pending_count", {123'd0, count}, 128'd1);
    wait_drain(10);

    // Overflow: 18 back-to-back writes with no reads
    g_master = 4'd1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_push(32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1, 3'd1);
      drive(1'b1, c_nonseq, 1'b1, 32'h3000 + 32'(i * 4), 3'd1,
            (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i - 1), 1'b1, 1'b1);
    end
    idle_cycle(32'hA000_0011);
    chk("ovf_count", {123'd0, count}, 128'd16);
    chk("ovf_flag", {127'd0, overflow}, 128'd1);
    chk("ovf_drop_cnt", {120'd0, drop_cnt}, 128'd2);

    // Push and pop at the same edge while full
    exp_push(32'h4000, 32'h44, 1'b1, 3'd0);
    drive(1'b1, c_nonseq, 1'b1, 32'h4000, 3'd0, 32'h0, 1'b1, 1'b1);
    drain = 1'b1;
    idle_cycle(32'h44);
    drain = 1'b0;
    idle_cycle(32'h0);
    chk("full_pushpop_count", {123'd0, count}, 128'd16);
    chk("full_pushpop_drop_cnt", {120'd0, drop_cnt}, 128'd2);

    // Drop coinciding with clear: set wins
    drive(1'b1, c_nonseq, 1'b1, 32'h5000, 3'd0, 32'h0, 1'b1, 1'b1);
    overflow_clr = 1'b1;
    idle_cycle(32'h55);
    overflow_clr = 1'b0;
    chk("clr_drop_overflow", {127'd0, overflow}, 128'd1);
    chk("clr_drop_drop_cnt", {120'd0, drop_cnt}, 128'd1);
    overflow_clr = 1'b1;
    idle_cycle(32'h0);
    overflow_clr = 1'b0;
    chk("clr_overflow", {127'd0, overflow}, 128'd0);
    chk("clr_drop_cnt", {120'd0, drop_cnt}, 128'd0);
    wait_drain(40);

    // Two accepts five cycles apart
    g_master = 4'd7;
    exp_push(32'h7000, 32'h70, 1'b1, 3'd0);
    drive(1'b1, c_nonseq, 1'b1, 32'h7000, 3'd0, 32'h0, 1'b1, 1'b1);
    idle_cycle(32'h70);
    repeat (3) idle_cycle(32'h0);
    exp_push(32'h7100, 32'h71, 1'b1, 3'd0);
    drive(1'b1, c_nonseq, 1'b1, 32'h7100, 3'd0, 32'h0, 1'b1, 1'b1);
    idle_cycle(32'h71);
    wait_drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
